cpu_controller: RTL and testbench

Multi-cycle control FSM for the 16-bit CPU. It sits directly upstream of `datapath`. It consumes the instruction register contents and the PSR flags, and drives every enable, mux-select and ALU-operation input of `datapath` once per state. Each instruction runs a fixed sequence: fetch, IR latch, decode, then one or two execute cycles.

---
 rtl/cpu_pkg.sv | 106 ++++++++++
 rtl/cond_eval.sv | 38 +++
 rtl/cpu_controller.sv | 160 ++++++++++++++++
 tb/tb_cpu_controller.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle CPU controller: states, instruction
// field codes, ALU operations, condition codes and datapath mux selects.
package cpu_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_LATCH, S_DECODE, S_ALU, S_MOV, S_LUI, S_LD_ADDR,
        S_LD_WB, S_STORE, S_JAL, S_JCOND, S_BRANCH, S_NOP
    } state_t;

    localparam logic [3:0] OP_REG   = 4'b0000;
    localparam logic [3:0] OP_SHIFT = 4'b1000;
    localparam logic [3:0] OP_MOVI  = 4'b1101;
    localparam logic [3:0] OP_LUI   = 4'b1111;
    localparam logic [3:0] OP_MEM   = 4'b0100;
    localparam logic [3:0] OP_BCOND = 4'b1100;

    // Register-form ext codes double as the opcodes of the immediate forms.
    localparam logic [3:0] EXT_ADD   = 4'b0101;
    localparam logic [3:0] EXT_SUB   = 4'b1001;
    localparam logic [3:0] EXT_CMP   = 4'b1011;
    localparam logic [3:0] EXT_AND   = 4'b0001;
    localparam logic [3:0] EXT_OR    = 4'b0010;
    localparam logic [3:0] EXT_XOR   = 4'b0011;
    localparam logic [3:0] EXT_MOV   = 4'b1101;
    localparam logic [3:0] EXT_LSH   = 4'b0100;
    localparam logic [3:0] EXT_LOAD  = 4'b0000;
    localparam logic [3:0] EXT_STOR  = 4'b0100;
    localparam logic [3:0] EXT_JAL   = 4'b1000;
    localparam logic [3:0] EXT_JCOND = 4'b1100;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_CMP  = 4'd2;
    localparam logic [3:0] ALU_AND  = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_LSH  = 4'd6;
    localparam logic [3:0] ALU_PASS = 4'd7;

    localparam logic [3:0] COND_EQ = 4'd0,  COND_NE = 4'd1,  COND_CS = 4'd2,  COND_CC = 4'd3;
    localparam logic [3:0] COND_HI = 4'd4,  COND_LS = 4'd5,  COND_GT = 4'd6,  COND_LE = 4'd7;
    localparam logic [3:0] COND_FS = 4'd8,  COND_FC = 4'd9,  COND_LO = 4'd10, COND_HS = 4'd11;
    localparam logic [3:0] COND_LT = 4'd12, COND_GE = 4'd13, COND_UC = 4'd14, COND_NV = 4'd15;

    localparam logic [1:0] PCM_INC  = 2'd0, PCM_REG  = 2'd1, PCM_ALU = 2'd2;
    localparam logic [1:0] MAM_PC   = 2'd0, MAM_REG  = 2'd1;
    localparam logic [1:0] A2M_REG  = 2'd0, A2M_IMM4 = 2'd1, A2M_SEXT = 2'd2;
    localparam logic [1:0] RWM_MEM  = 2'd0, RWM_PC1  = 2'd1, RWM_ALU = 2'd2, RWM_LUI = 2'd3;

    typedef struct packed {
        logic       mem_w1_en;
        logic       rf_en;
        logic       psr_en;
        logic       pc_en;
        logic       instr_en;
        logic       movm;
        logic       a1m;
        logic       set_znl;
        logic [1:0] pcm;
        logic [1:0] mam;
        logic [1:0] a2m;
        logic [1:0] rwm;
        logic [3:0] alu_op;
    } ctrl_t;

    function automatic logic is_alu_code(input logic [3:0] code);
        return code inside {EXT_ADD, EXT_SUB, EXT_CMP, EXT_AND, EXT_OR, EXT_XOR};
    endfunction

    function automatic logic [3:0] alu_code(input logic [3:0] code);
        case (code)
            EXT_SUB: return ALU_SUB;
            EXT_CMP: return ALU_CMP;
            EXT_AND: return ALU_AND;
            EXT_OR:  return ALU_OR;
            EXT_XOR: return ALU_XOR;
            default: return ALU_ADD;
        endcase
    endfunction

    function automatic state_t decode_state(input logic [3:0] op, input logic [3:0] ext);
        if (op == OP_REG) begin
            if (is_alu_code(ext)) return S_ALU;
            if (ext == EXT_MOV)   return S_MOV;
            return S_NOP;
        end
        if (is_alu_code(op)) return S_ALU;
        case (op)
            OP_SHIFT: return (ext == EXT_LSH || ext[3:1] == 3'b000) ? S_ALU : S_NOP;
            OP_MOVI:  return S_MOV;
            OP_LUI:   return S_LUI;
            OP_BCOND: return S_BRANCH;
            OP_MEM: begin
                case (ext)
                    EXT_LOAD:  return S_LD_ADDR;
                    EXT_STOR:  return S_STORE;
                    EXT_JAL:   return S_JAL;
                    EXT_JCOND: return S_JCOND;
                    default:   return S_NOP;
                endcase
            end
            default:  return S_NOP;
        endcase
    endfunction

endpackage

// File: rtl/cond_eval.sv
// Branch/jump condition evaluator: decides from the 4-bit condition field
// and the PSR flags whether the transfer is taken.
module cond_eval
    import cpu_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [1:0] flags1,
    input  logic [2:0] flags2,
    output logic       take
);

    logic c, f, z, n, l;
    assign {c, f}    = flags1;
    assign {z, n, l} = flags2;

    always_comb begin
        take = 1'b0;
        case (cond)
            COND_EQ: take = z;
            COND_NE: take = !z;
            COND_CS: take = c;
            COND_CC: take = !c;
            COND_HI: take = l;
            COND_LS: take = !l;
            COND_GT: take = n;
            COND_LE: take = !n;
            COND_FS: take = f;
            COND_FC: take = !f;
            COND_LO: take = !l && !z;
            COND_HS: take = l || z;
            COND_LT: take = !n && !z;
            COND_GE: take = n || z;
            COND_UC: take = 1'b1;
            default: take = 1'b0;
        endcase
    end

endmodule

// File: rtl/cpu_controller.sv
// Multi-cycle control FSM: fetch, IR latch, decode, then one or two execute
// cycles; drives every datapath enable/select combinationally from the state.
module cpu_controller
    import cpu_pkg::*;
#(
    parameter int SIZE = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [SIZE-1:0] instr,
    input  logic [1:0]      flags1out,
    input  logic [2:0]      flags2out,
    output logic            MemW1en,
    output logic            MemW2en,
    output logic            RFen,
    output logic            PSRen,
    output logic            PCen,
    output logic            INSTRen,
    output logic            Movm,
    output logic            A1m,
    output logic            setZNL,
    output logic [1:0]      PCm,
    output logic [1:0]      MAm,
    output logic [1:0]      A2m,
    output logic [1:0]      RWm,
    output logic [3:0]      aluOp
);

    state_t     state_q, state_d;
    ctrl_t      ctrl;
    logic [3:0] opcode, cond, ext;
    logic       take;

    assign opcode = instr[15:12];
    assign cond   = instr[11:8];
    assign ext    = instr[7:4];

    // Rsrc is consumed only by the datapath.
    logic unused_rsrc;
    assign unused_rsrc = ^instr[3:0];

    cond_eval u_cond_eval (
        .cond   (cond),
        .flags1 (flags1out),
        .flags2 (flags2out),
        .take   (take)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:   state_d = S_LATCH;
            S_LATCH:   state_d = S_DECODE;
            S_DECODE:  state_d = decode_state(opcode, ext);
            S_LD_ADDR: state_d = S_LD_WB;
            default:   state_d = S_FETCH;
        endcase
    end

    // NOTE: non-blocking assignment keeps every flop updating from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // NOTE: ctrl gets a full default first so no path through the case infers a latch.
    always_comb begin
        ctrl        = '0;
        ctrl.alu_op = ALU_ADD;
        case (state_q)
            S_FETCH: ctrl.mam = MAM_PC;
            S_LATCH: begin
                ctrl.instr_en = 1'b1;
                ctrl.mam      = MAM_PC;
            end
            S_ALU: begin
                ctrl.movm  = 1'b1;
                ctrl.a1m   = 1'b0;
                ctrl.rwm   = RWM_ALU;
                ctrl.pc_en = 1'b1;
                ctrl.pcm   = PCM_INC;
                if (opcode == OP_SHIFT) begin
                    ctrl.alu_op = ALU_LSH;
                    ctrl.a2m    = (ext == EXT_LSH) ? A2M_REG : A2M_IMM4;
                end else if (opcode == OP_REG) begin
                    ctrl.alu_op = alu_code(ext);
                    ctrl.a2m    = A2M_REG;
                end else begin
                    ctrl.alu_op = alu_code(opcode);
                    ctrl.a2m    = A2M_SEXT;
                end
                ctrl.rf_en   = (ctrl.alu_op != ALU_CMP);
                ctrl.psr_en  = ctrl.alu_op inside {ALU_ADD, ALU_SUB, ALU_CMP};
                ctrl.set_znl = ctrl.psr_en;
            end
            S_MOV: begin
                ctrl.movm  = 1'b0;
                ctrl.a2m   = (opcode == OP_REG) ? A2M_REG : A2M_SEXT;
                ctrl.rwm   = RWM_ALU;
                ctrl.rf_en = 1'b1;
                ctrl.pc_en = 1'b1;
            end
            S_LUI: begin
                ctrl.rwm   = RWM_LUI;
                ctrl.rf_en = 1'b1;
                ctrl.pc_en = 1'b1;
            end
            S_LD_ADDR: ctrl.mam = MAM_REG;
            S_LD_WB: begin
                ctrl.mam   = MAM_REG;
                ctrl.rwm   = RWM_MEM;
                ctrl.rf_en = 1'b1;
                ctrl.pc_en = 1'b1;
            end
            S_STORE: begin
                ctrl.mam       = MAM_REG;
                ctrl.mem_w1_en = 1'b1;
                ctrl.pc_en     = 1'b1;
            end
            S_JAL: begin
                ctrl.rwm   = RWM_PC1;
                ctrl.rf_en = 1'b1;
                ctrl.pcm   = PCM_REG;
                ctrl.pc_en = 1'b1;
            end
            S_JCOND: begin
                ctrl.pcm   = take ? PCM_REG : PCM_INC;
                ctrl.pc_en = 1'b1;
            end
            S_BRANCH: begin
                ctrl.a1m    = 1'b1;
                ctrl.a2m    = A2M_SEXT;
                ctrl.alu_op = ALU_ADD;
                ctrl.pcm    = take ? PCM_ALU : PCM_INC;
                ctrl.pc_en  = 1'b1;
            end
            S_NOP: begin
                ctrl.pc_en = 1'b1;
                ctrl.pcm   = PCM_INC;
            end
            default: ;
        endcase
    end

    assign MemW1en = ctrl.mem_w1_en;
    assign MemW2en = 1'b0;
    assign RFen    = ctrl.rf_en;
    assign PSRen   = ctrl.psr_en;
    assign PCen    = ctrl.pc_en;
    assign INSTRen = ctrl.instr_en;
    assign Movm    = ctrl.movm;
    assign A1m     = ctrl.a1m;
    assign setZNL  = ctrl.set_znl;
    assign PCm     = ctrl.pcm;
    assign MAm     = ctrl.mam;
    assign A2m     = ctrl.a2m;
    assign RWm     = ctrl.rwm;
    assign aluOp   = ctrl.alu_op;

endmodule

// File: tb/tb_cpu_controller.sv
// Scoreboard bench for cpu_controller: each instruction pushes its expected
// per-cycle control vectors, a negedge monitor pops and compares them.
module tb_cpu_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] instr;
    logic [1:0]  flags1out;
    logic [2:0]  flags2out;
    logic        MemW1en, MemW2en, RFen, PSRen, PCen, INSTRen, Movm, A1m, setZNL;
    logic [1:0]  PCm, MAm, A2m, RWm;
    logic [3:0]  aluOp;

    cpu_controller #(.SIZE(16)) dut (
        .clk(clk), .reset(reset), .instr(instr),
        .flags1out(flags1out), .flags2out(flags2out),
        .MemW1en(MemW1en), .MemW2en(MemW2en), .RFen(RFen), .PSRen(PSRen),
        .PCen(PCen), .INSTRen(INSTRen), .Movm(Movm), .A1m(A1m), .setZNL(setZNL),
        .PCm(PCm), .MAm(MAm), .A2m(A2m), .RWm(RWm), .aluOp(aluOp)
    );

    always #5 clk = ~clk;

    // {MemW1en,MemW2en,RFen,PSRen,PCen,INSTRen,Movm,A1m,setZNL,PCm,MAm,A2m,RWm,aluOp}
    logic [20:0] obs;
    assign obs = {MemW1en, MemW2en, RFen, PSRen, PCen, INSTRen, Movm, A1m, setZNL,
                  PCm, MAm, A2m, RWm, aluOp};

    localparam logic [20:0] V_IDLE  = 21'h0;
    localparam logic [20:0] V_LATCH = 21'h0 | (21'd1 << 15);

    int          n_vec  = 0;
    int          n_miss = 0;
    logic [20:0] sb_q[$];
    bit          sb_on  = 1'b0;
    string       cur_tag = "";

    task automatic check(input string tag, input logic [20:0] got, input logic [20:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s got=%06h exp=%06h", tag, got, exp);
        end
    endtask

    function automatic logic [20:0] mk(input bit w1, input bit rf, input bit psr, input bit pc,
                                       input bit movm, input bit a1m, input bit znl,
                                       input logic [1:0] pcm, input logic [1:0] mam,
                                       input logic [1:0] a2m, input logic [1:0] rwm,
                                       input logic [3:0] op);
        return {w1, 1'b0, rf, psr, pc, 1'b0, movm, a1m, znl, pcm, mam, a2m, rwm, op};
    endfunction

    function automatic bit take_exp(input logic [3:0] c, input logic [1:0] f1, input logic [2:0] f2);
        bit cf, ff, zf, nf, lf;
        {cf, ff}     = f1;
        {zf, nf, lf} = f2;
        case (c)
            4'd0:  return zf;
            4'd1:  return !zf;
            4'd2:  return cf;
            4'd3:  return !cf;
            4'd4:  return lf;
            4'd5:  return !lf;
            4'd6:  return nf;
            4'd7:  return !nf;
            4'd8:  return ff;
            4'd9:  return !ff;
            4'd10: return !lf && !zf;
            4'd11: return lf || zf;
            4'd12: return !nf && !zf;
            4'd13: return nf || zf;
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    always @(negedge clk) begin
        if (sb_on && sb_q.size() > 0) check(cur_tag, obs, sb_q.pop_front());
    end

    // Called just after a rising edge with the DUT in S_FETCH.
    task automatic run(input string tag, input logic [15:0] ins, input logic [1:0] f1,
                       input logic [2:0] f2, input logic [20:0] e1,
                       input bit two, input logic [20:0] e2);
        cur_tag   = tag;
        instr     = ins;
        flags1out = f1;
        flags2out = f2;
        sb_q.push_back(V_IDLE);
        sb_q.push_back(V_LATCH);
        sb_q.push_back(V_IDLE);
        sb_q.push_back(e1);
        if (two) sb_q.push_back(e2);
        repeat (two ? 5 : 4) @(posedge clk);
        #1;
    endtask

    task automatic run1(input string tag, input logic [15:0] ins, input logic [1:0] f1,
                        input logic [2:0] f2, input logic [20:0] e1);
        run(tag, ins, f1, f2, e1, 1'b0, V_IDLE);
    endtask

    initial begin
        reset     = 1'b1;
        instr     = 16'h0000;
        flags1out = 2'b00;
        flags2out = 3'b000;
        #2;
        check("reset_state", obs, V_IDLE);
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb_on = 1'b1;

        run1("add",  16'h0152, 2'b00, 3'b000, mk(0,1,1,1,1,0,1, 0,0,0,2, 4'd0));
        run1("cmp",  16'h01B2, 2'b00, 3'b000, mk(0,0,1,1,1,0,1, 0,0,0,2, 4'd2));
        run1("sub",  16'h0192, 2'b00, 3'b000, mk(0,1,1,1,1,0,1, 0,0,0,2, 4'd1));
        run1("and",  16'h0312, 2'b00, 3'b000, mk(0,1,0,1,1,0,0, 0,0,0,2, 4'd3));
        run1("or",   16'h0222, 2'b00, 3'b000, mk(0,1,0,1,1,0,0, 0,0,0,2, 4'd4));
        run1("addi", 16'h5105, 2'b00, 3'b000, mk(0,1,1,1,1,0,1, 0,0,2,2, 4'd0));
        run1("cmpi", 16'hB1FF, 2'b00, 3'b000, mk(0,0,1,1,1,0,1, 0,0,2,2, 4'd2));
        run1("xori", 16'h3107, 2'b00, 3'b000, mk(0,1,0,1,1,0,0, 0,0,2,2, 4'd5));
        run1("lsh",  16'h8143, 2'b00, 3'b000, mk(0,1,0,1,1,0,0, 0,0,0,2, 4'd6));
        run1("lshi", 16'h8113, 2'b00, 3'b000, mk(0,1,0,1,1,0,0, 0,0,1,2, 4'd6));
        run1("mov",  16'h01D2, 2'b00, 3'b000, mk(0,1,0,1,0,0,0, 0,0,0,2, 4'd0));
        run1("movi", 16'hD1FF, 2'b00, 3'b000, mk(0,1,0,1,0,0,0, 0,0,2,2, 4'd0));
        run1("lui",  16'hF1AB, 2'b00, 3'b000, mk(0,1,0,1,0,0,0, 0,0,0,3, 4'd0));
        run("load",  16'h4302, 2'b00, 3'b000, mk(0,0,0,0,0,0,0, 0,1,0,0, 4'd0),
            1'b1, mk(0,1,0,1,0,0,0, 0,1,0,0, 4'd0));
        run1("stor", 16'h4241, 2'b00, 3'b000, mk(1,0,0,1,0,0,0, 0,1,0,0, 4'd0));
        run1("jal",  16'h4E83, 2'b00, 3'b000, mk(0,1,0,1,0,0,0, 1,0,0,1, 4'd0));
        run1("jeq_t", 16'h40C3, 2'b00, 3'b100, mk(0,0,0,1,0,0,0, 1,0,0,0, 4'd0));
        run1("jeq_n", 16'h40C3, 2'b11, 3'b011, mk(0,0,0,1,0,0,0, 0,0,0,0, 4'd0));
        run1("beq_t", 16'hC0FE, 2'b00, 3'b100, mk(0,0,0,1,0,1,0, 2,0,2,0, 4'd0));
        run1("beq_n", 16'hC0FE, 2'b11, 3'b011, mk(0,0,0,1,0,1,0, 0,0,2,0, 4'd0));
        run1("buc",  16'hCEFE, 2'b00, 3'b000, mk(0,0,0,1,0,1,0, 2,0,2,0, 4'd0));
        run1("bnv",  16'hCFFE, 2'b11, 3'b111, mk(0,0,0,1,0,1,0, 0,0,2,0, 4'd0));
        run1("nop7", 16'h7000, 2'b00, 3'b000, mk(0,0,0,1,0,0,0, 0,0,0,0, 4'd0));
        run1("nopx", 16'h00F0, 2'b00, 3'b000, mk(0,0,0,1,0,0,0, 0,0,0,0, 4'd0));
        run1("nopm", 16'h4010, 2'b00, 3'b000, mk(0,0,0,1,0,0,0, 0,0,0,0, 4'd0));
        run1("nops", 16'h8123, 2'b00, 3'b000, mk(0,0,0,1,0,0,0, 0,0,0,0, 4'd0));

        for (int c = 0; c < 16; c++) begin
            for (int k = 0; k < 2; k++) begin
                logic [1:0]  f1;
                logic [2:0]  f2;
                logic [15:0] ins;
                f1  = 2'($urandom_range(0, 3));
                f2  = 3'($urandom_range(0, 7));
                ins = {4'hC, 4'(c), 8'h05};
                run1($sformatf("bcond_%0d", c), ins, f1, f2,
                     mk(0,0,0,1,0,1,0, take_exp(4'(c), f1, f2) ? 2'd2 : 2'd0, 0,2,0, 4'd0));
                ins = {4'h4, 4'(c), 4'hC, 4'h3};
                run1($sformatf("jcond_%0d", c), ins, f1, f2,
                     mk(0,0,0,1,0,0,0, take_exp(4'(c), f1, f2) ? 2'd1 : 2'd0, 0,0,0, 4'd0));
            end
        end

        sb_on = 1'b0;
        check("sb_drain", 21'(sb_q.size()), 21'd0);

        // Reset asserted in the middle of a store cycle.
        instr = 16'h4241;
        repeat (3) @(posedge clk);
        #2;
        check("st_before_rst", obs, mk(1,0,0,1,0,0,0, 0,1,0,0, 4'd0));
        reset = 1'b1;
        #1;
        check("rst_async", obs, V_IDLE);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rel_fetch", obs, V_IDLE);
        @(negedge clk);
        check("rel_latch", obs, V_LATCH);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
